// File: rtl/wb_sel_arb_pkg.sv
// Shared types and the round-robin search used by the writeback select arbiter.
// rr_pick scans from last+1 upward with wrap-around and reports the first requester found.
package wb_sel_arb_pkg;

  localparam int MAX_REQ = 16;
  localparam int SEL_W   = 4;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic found;
    sel_t idx;
  } pick_t;

  // The descending scan lets the smallest distance from last win.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req, input sel_t last,
                                    input int unsigned n);
    pick_t       r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = n; k >= 1; k--) begin
      idx = (32'(last) + k) % n;
      if (req[idx[3:0]]) begin
        r.found = 1'b1;
        r.idx   = idx[3:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_sel_arbiter_if.sv
// Writeback select handshake: requests in, registered select plus valid/ready and grant pulses out.
// The slave modport is the arbiter side, the master modport the requester/consumer side.
interface wb_sel_arbiter_if #(parameter int N_REQ = 11);
  import wb_sel_arb_pkg::*;

  logic [N_REQ-1:0] req;
  sel_t             sel;
  logic             out_valid;
  logic             out_ready;
  logic [N_REQ-1:0] gnt;
  logic             busy;

  modport master (output req, output out_ready, input sel, input out_valid, input gnt, input busy);
  modport slave  (input req, input out_ready, output sel, output out_valid, output gnt, output busy);

endinterface

// File: rtl/wb_sel_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: rotate past last, find first set request, map back to an index.
// Zero latency; found is low when no request is present.
module rr_priority_pick
  import wb_sel_arb_pkg::*;
#(
  parameter int N_REQ = 11
) (
  input  logic [N_REQ-1:0] req,
  input  sel_t             last,
  output logic             found,
  output sel_t             winner
);

  logic [MAX_REQ-1:0] req_ext;
  pick_t              pick;

  always_comb begin
    req_ext = MAX_REQ'(req);
    pick    = rr_pick(req_ext, last, N_REQ);
    found   = pick.found;
    winner  = pick.idx;
  end

endmodule

// File: rtl/wb_sel_arbiter.sv
// Round-robin writeback select arbiter: 1 cycle req->out_valid, back-to-back grants with no bubble.
// Holds sel stable while out_ready is low. WB_SEL_ARB_PERF_CNT_EN adds grant/stall counters.
module wb_sel_arbiter
  import wb_sel_arb_pkg::*;
#(
  parameter int N_REQ = 11
) (
  input  logic               clk,
  input  logic               rst,
  wb_sel_arbiter_if.slave    bus
`ifdef WB_SEL_ARB_PERF_CNT_EN
  ,
  output logic [15:0]        grant_cnt [N_REQ],
  output logic [15:0]        stall_cnt
`endif
);

  arb_state_e       state_q, state_d;
  sel_t             sel_q, sel_d;
  sel_t             last_q, last_d;
  logic [N_REQ-1:0] self_mask;
  logic [N_REQ-1:0] pick_req;
  sel_t             pick_last;
  logic             pick_found;
  sel_t             pick_winner;
  logic             accept;

  assign accept = (state_q == HOLD) && bus.out_ready;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      self_mask[i] = (sel_q == SEL_W'(i));
    end
  end

  // In HOLD the winner being granted is masked out so the next pick starts past it.
  assign pick_req  = (state_q == HOLD) ? (bus.req & ~self_mask) : bus.req;
  assign pick_last = (state_q == HOLD) ? sel_q : last_q;

  rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (pick_req),
    .last   (pick_last),
    .found  (pick_found),
    .winner (pick_winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = HOLD;
          sel_d   = pick_winner;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          last_d = sel_q;
          if (pick_found) begin
            sel_d = pick_winner;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sel       = sel_q;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q == HOLD);
  assign bus.gnt       = accept ? self_mask : '0;

`ifdef WB_SEL_ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        grant_cnt[i] <= '0;
      end
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.gnt[i] && (grant_cnt[i] != 16'hFFFF)) begin
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
        end
      end
      if ((state_q == HOLD) && !bus.out_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_sel_arbiter.sv
// Directed-vector bench for wb_sel_arbiter with hand-computed expectations.
// Inputs change on the falling edge; outputs are checked just before the next rising edge.
module tb_wb_sel_arbiter;
  import wb_sel_arb_pkg::*;

  localparam int N = 11;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   gcount [N];

  wb_sel_arbiter_if #(.N_REQ(N)) bus ();

`ifdef WB_SEL_ARB_PERF_CNT_EN
  logic [15:0] grant_cnt [N];
  logic [15:0] stall_cnt;
`endif

  wb_sel_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef WB_SEL_ARB_PERF_CNT_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.req       = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic v, input int s, input logic [N-1:0] g);
    check_val({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    if (v) check_val({tag, "_sel"}, 32'(bus.sel), 32'(s));
    check_val({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
  endtask

  initial begin
    logic [N-1:0] one;
    checks   = 0;
    failures = 0;
    one      = 11'h001;
    rst      = 1'b0;

    do_reset();
    check_val("rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_sel", 32'(bus.sel), 32'd0);
    check_val("rst_gnt", 32'(bus.gnt), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);

    // Single requester: granted, then self-masked back to idle.
    bus.req = 11'h001; bus.out_ready = 1'b1;
    step();
    expect_out("single_c1", 1'b1, 0, 11'h001);
    check_val("single_busy", 32'(bus.busy), 32'd1);
    step();
    expect_out("single_c2", 1'b0, 0, 11'h000);
    bus.req = '0;
    step();

    // All requesting: strict rotation without bubbles.
    do_reset();
    for (int i = 0; i < N; i++) gcount[i] = 0;
    bus.req = 11'h7FF; bus.out_ready = 1'b1;
    step();
    for (int c = 0; c < 22; c++) begin
      expect_out("rr_all", 1'b1, c % N, one << (c % N));
      for (int i = 0; i < N; i++) if (bus.gnt[i]) gcount[i]++;
      if (c == 21) bus.req = '0;
      step();
    end
    check_val("rr_all_end_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < N; i++) check_val("rr_all_gcount", 32'(gcount[i]), 32'd2);

    // Stall holds sel; release grants 2 then 5 follows immediately.
    do_reset();
    bus.req = 11'h024; bus.out_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      expect_out("stall_hold", 1'b1, 2, 11'h000);
      if (i < 4) step();
    end
    bus.out_ready = 1'b1;
    #1;
    expect_out("stall_rel", 1'b1, 2, 11'h004);
    step();
    bus.req = 11'h020;
    #1;
    expect_out("stall_next", 1'b1, 5, 11'h020);
    step();
    bus.req = '0;
    #1;
    check_val("stall_end_valid", 32'(bus.out_valid), 32'd0);

    // Wrap-around: last=5 -> 0 wins; last=4 -> 5 wins.
    do_reset();
    bus.req = 11'h020; bus.out_ready = 1'b1;
    step();
    expect_out("wrap_prep5", 1'b1, 5, 11'h020);
    bus.req = '0;
    step();
    bus.req = 11'h021;
    step();
    expect_out("wrap_last5", 1'b1, 0, 11'h001);
    do_reset();
    bus.req = 11'h010; bus.out_ready = 1'b1;
    step();
    expect_out("wrap_prep4", 1'b1, 4, 11'h010);
    bus.req = '0;
    step();
    bus.req = 11'h021;
    step();
    expect_out("wrap_last4", 1'b1, 5, 11'h020);

    // Async reset mid-HOLD aborts the transfer.
    do_reset();
    bus.req = 11'h080; bus.out_ready = 1'b0;
    step();
    expect_out("mid_rst_pre", 1'b1, 7, 11'h000);
    #2;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check_val("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("mid_rst_sel", 32'(bus.sel), 32'd0);
    check_val("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    bus.req = 11'h081;
    rst = 1'b0;
    step();
    expect_out("mid_rst_restart", 1'b1, 0, 11'h001);
    bus.req = '0; bus.out_ready = 1'b0;

`ifdef WB_SEL_ARB_PERF_CNT_EN
    do_reset();
    bus.req = 11'h008; bus.out_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) step();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus.req = '0; bus.out_ready = 1'b0;
    step();
    check_val("perf_grant3", 32'(grant_cnt[3]), 32'd3);
    check_val("perf_grant0", 32'(grant_cnt[0]), 32'd0);
    check_val("perf_stall", 32'(stall_cnt), 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
